br_redirect_ctrl: RTL and testbench

Sequencing controller for branch redirects between the execute-stage branch unit and instruction fetch. It accepts one resolved branch result per handshake and filters out results from squashed (stale-epoch) instructions. For a taken or indirect branch it advances the pipeline epoch, presents the target to the IFU on a valid/ready channel, and holds a flush to the younger stages for a fixed drain window. The EXU is back-pressured while a redirect is in flight, so at most one redirect is outstanding.

---
 rtl/br_redirect_ctrl.sv | 88 ++++++++
 tb/tb_br_redirect_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/br_redirect_ctrl.sv
// Branch redirect sequencer between the EXU branch unit and the IFU.
// Filters stale-epoch results, issues one redirect at a time and holds flush for a drain window.
module br_redirect_ctrl #(
   parameter int unsigned EPOCH_W      = 2,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ex_valid,
   output logic               ex_ready,
   input  logic               ex_redirect,
   input  logic [63:0]        ex_target,
   input  logic [EPOCH_W-1:0] ex_epoch,
   output logic               ifu_redir_valid,
   input  logic               ifu_redir_ready,
   output logic [63:0]        ifu_redir_pc,
   output logic               flush,
   output logic [EPOCH_W-1:0] cur_epoch,
   output logic [CNT_W-1:0]   redirect_cnt,
   output logic [CNT_W-1:0]   stale_cnt
);

   localparam int unsigned DRAIN_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             state;
   logic [DRAIN_W-1:0] drain_cnt;

   // EXU is only accepted while no redirect is in flight
   assign ex_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         drain_cnt       <= '0;
         cur_epoch       <= '0;
         ifu_redir_valid <= 1'b0;
         ifu_redir_pc    <= '0;
         flush           <= 1'b0;
         redirect_cnt    <= '0;
         stale_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (ex_valid) begin
                  if (ex_epoch != cur_epoch) begin
                     if (stale_cnt != '1) stale_cnt <= stale_cnt + CNT_W'(1);
                  end else if (ex_redirect) begin
                     ifu_redir_pc    <= ex_target & ~64'h1;
                     cur_epoch       <= cur_epoch + EPOCH_W'(1);
                     ifu_redir_valid <= 1'b1;
                     flush           <= 1'b1;
                     state           <= REQ;
                  end
               end
            end
            REQ: begin
               if (ifu_redir_ready) begin
                  if (redirect_cnt != '1) redirect_cnt <= redirect_cnt + CNT_W'(1);
                  ifu_redir_valid <= 1'b0;
                  drain_cnt       <= DRAIN_W'(FLUSH_CYCLES);
                  state           <= DRAIN;
               end
            end
            DRAIN: begin
               // flush is released on the last drain cycle's edge
               drain_cnt <= drain_cnt - DRAIN_W'(1);
               if (drain_cnt == DRAIN_W'(1)) begin
                  flush <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               ifu_redir_valid <= 1'b0;
               flush           <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Self-checking bench for br_redirect_ctrl: timestamp-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_br_redirect_ctrl;

   localparam int unsigned EPOCH_W = 2;
   localparam int unsigned FLUSH_CYCLES = 2;
   localparam int unsigned CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               ex_valid = 1'b0;
   logic               ex_ready;
   logic               ex_redirect = 1'b0;
   logic [63:0]        ex_target = '0;
   logic [EPOCH_W-1:0] ex_epoch = '0;
   logic               ifu_redir_valid;
   logic               ifu_redir_ready = 1'b0;
   logic [63:0]        ifu_redir_pc;
   logic               flush;
   logic [EPOCH_W-1:0] cur_epoch;
   logic [CNT_W-1:0]   redirect_cnt;
   logic [CNT_W-1:0]   stale_cnt;

   br_redirect_ctrl #(
      .EPOCH_W(EPOCH_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_redirect(ex_redirect),
      .ex_target(ex_target), .ex_epoch(ex_epoch),
      .ifu_redir_valid(ifu_redir_valid), .ifu_redir_ready(ifu_redir_ready),
      .ifu_redir_pc(ifu_redir_pc), .flush(flush), .cur_epoch(cur_epoch),
      .redirect_cnt(redirect_cnt), .stale_cnt(stale_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a redirect is "requested" until the IFU takes it; flush then
   // lasts until a cycle timestamp, and the EXU is accepted only after that timestamp.
   int          k = 0;
   bit          m_req;
   int          m_flush_end;
   int          m_epoch;
   int          m_redir;
   int          m_stale;
   logic [63:0] m_pc;

   function automatic bit m_ready();
      return !m_req && (k > m_flush_end);
   endfunction

   task automatic model_reset();
      m_req = 0; m_flush_end = -1; m_epoch = 0; m_redir = 0; m_stale = 0; m_pc = '0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         check("ex_ready", 64'(ex_ready), 64'(m_ready()));
         check("ifu_redir_valid", 64'(ifu_redir_valid), 64'(m_req));
         check("flush", 64'(flush), 64'(m_req || (k <= m_flush_end)));
         check("cur_epoch", 64'(cur_epoch), 64'(m_epoch));
         check("redirect_cnt", 64'(redirect_cnt), 64'(m_redir));
         check("stale_cnt", 64'(stale_cnt), 64'(m_stale));
         check("ifu_redir_pc", ifu_redir_pc, m_pc);
         if (rst_n) begin
            if (m_req) begin
               if (ifu_redir_ready) begin
                  m_req = 0;
                  m_flush_end = k + int'(FLUSH_CYCLES);
                  if (m_redir < CNT_MAX) m_redir++;
               end
            end else if (m_ready() && ex_valid) begin
               if (int'(ex_epoch) != m_epoch) begin
                  if (m_stale < CNT_MAX) m_stale++;
               end else if (ex_redirect) begin
                  m_req = 1;
                  m_pc = {ex_target[63:1], 1'b0};
                  m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
               end
            end
         end
         k++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic r, input logic [63:0] t, input int ep);
      ex_valid = v; ex_redirect = r; ex_target = t; ex_epoch = EPOCH_W'(ep);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, '0, 0);
      tick(); tick();
      rst_n = 1'b1;
   endtask

   logic [EPOCH_W-1:0] seq [5];
   logic [63:0]        tgt;

   initial begin
      seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      #1;
      check("reset ex_ready low-phase", 64'(ex_ready), 64'd1);
      check("reset valid", 64'(ifu_redir_valid), 64'd0);
      do_reset();
      check("post-reset epoch", 64'(cur_epoch), 64'd0);
      check("post-reset ex_ready", 64'(ex_ready), 64'd1);

      // Single taken branch, IFU always ready
      ifu_redir_ready = 1'b1;
      drive(1, 1, 64'h8000_0103, 0);
      tick();
      drive(0, 0, '0, 0);
      check("t1 pc", ifu_redir_pc, 64'h8000_0102);
      check("t1 valid", 64'(ifu_redir_valid), 64'd1);
      check("t1 flush", 64'(flush), 64'd1);
      check("t1 epoch", 64'(cur_epoch), 64'd1);
      check("t1 ex_ready", 64'(ex_ready), 64'd0);
      tick();
      check("t2 valid", 64'(ifu_redir_valid), 64'd0);
      check("t2 flush", 64'(flush), 64'd1);
      check("t2 redirect_cnt", 64'(redirect_cnt), 64'd1);
      tick();
      check("t3 flush", 64'(flush), 64'd1);
      check("t3 ex_ready", 64'(ex_ready), 64'd0);
      tick();
      check("t4 flush", 64'(flush), 64'd0);
      check("t4 ex_ready", 64'(ex_ready), 64'd1);

      // IFU back-pressure for 5 cycles, handshake on the 6th
      ifu_redir_ready = 1'b0;
      drive(1, 1, 64'h0000_1235, 1);
      tick();
      drive(0, 0, '0, 0);
      for (int i = 0; i < 6; i++) begin
         check("bp valid", 64'(ifu_redir_valid), 64'd1);
         check("bp pc", ifu_redir_pc, 64'h0000_1234);
         check("bp flush", 64'(flush), 64'd1);
         check("bp ex_ready", 64'(ex_ready), 64'd0);
         if (i == 5) ifu_redir_ready = 1'b1;
         tick();
      end
      check("bp after valid", 64'(ifu_redir_valid), 64'd0);
      check("bp redirect_cnt", 64'(redirect_cnt), 64'd2);
      tick();
      check("bp ex_ready H+2", 64'(ex_ready), 64'd0);
      tick();
      check("bp ex_ready H+3", 64'(ex_ready), 64'd1);

      // Stale and not-taken results at cur_epoch = 1
      do_reset();
      drive(1, 1, 64'h40, 0);
      tick();
      drive(0, 0, '0, 0);
      tick(); tick(); tick();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1, 1, 64'h100 + 64'(i), 0);
         else drive(1, 0, 64'h200, 1);
         tick();
         check("stale valid", 64'(ifu_redir_valid), 64'd0);
         check("stale ex_ready", 64'(ex_ready), 64'd1);
         check("stale epoch", 64'(cur_epoch), 64'd1);
      end
      drive(0, 0, '0, 0);
      check("stale_cnt", 64'(stale_cnt), 64'd3);

      // Epoch wrap over 5 back-to-back redirects
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 64'h1000 * 64'(i + 1), i % 4);
         tick();
         drive(0, 0, '0, 0);
         tick(); tick(); tick();
         check("wrap epoch", 64'(cur_epoch), 64'(seq[i]));
         check("wrap ex_ready", 64'(ex_ready), 64'd1);
      end
      check("wrap redirect_cnt", 64'(redirect_cnt), 64'd5);

      // Asynchronous reset while a redirect is requested
      ifu_redir_ready = 1'b0;
      drive(1, 1, 64'hdead_beef, 1);
      tick();
      drive(0, 0, '0, 0);
      check("mid valid before rst", 64'(ifu_redir_valid), 64'd1);
      ifu_redir_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("async valid", 64'(ifu_redir_valid), 64'd0);
      check("async flush", 64'(flush), 64'd0);
      check("async ex_ready", 64'(ex_ready), 64'd1);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("rst redirect_cnt", 64'(redirect_cnt), 64'd0);
      check("rst epoch", 64'(cur_epoch), 64'd0);

      // Stale counter saturation
      for (int i = 0; i < 17; i++) begin
         drive(1, i[0], 64'(i), 2);
         tick();
      end
      drive(0, 0, '0, 0);
      check("stale saturate", 64'(stale_cnt), 64'd15);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         tgt = {$urandom(), $urandom()};
         drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), tgt,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : m_epoch);
         ifu_redir_ready = 1'($urandom_range(0, 9) < 7);
         tick();
      end
      drive(0, 0, '0, 0);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
